cmd_frame_decoder: RTL
======================

Name: cmd_frame_decoder

Overview:
- Parametrised successor to the single-byte command decoder.
- Assembles framed, checksummed multi-byte commands from the host byte interface (sync, opcode, N argument bytes, XOR checksum).
- Emits a one-cycle pulse per recognised command, with its argument, and maintains a sticky USB/SD output-mode register.
- Sits between the host command receiver and the CMOS capture / DDR3 / SD control logic; adds error detection, a timeout and an error counter.

Parameters:
- DATA_W, 8: command byte width.
- NUM_CMD, 4: number of recognised opcodes, 1..8; codes taken from the package table, in index order.
- ARG_BYTES, 2: argument bytes per frame, 0..4.
- SYNC_BYTE, 8'hEB: frame start marker.
- TIMEOUT_CYC, 1024: maximum idle cycles between bytes inside a frame; must be >= 2.
- ERR_W, 16: error counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- command_latch  in  1  byte strobe, synchronous to clk; a byte is accepted on its rising edge.
- command_data  in  DATA_W  command byte, valid while command_latch is high.
- cmd_pulse  out  NUM_CMD  one-hot, one-cycle pulse for the decoded command.
- cmd_valid  out  1  one-cycle pulse, coincident with any cmd_pulse bit.
- cmd_arg  out  8*max(ARG_BYTES,1)  argument of the last good frame, first byte in the MSBs; held until the next good frame.
- mode_usb  out  1  sticky: USB output selected.
- mode_sd  out  1  sticky: SD output selected.
- frame_err  out  1  one-cycle pulse on any frame error.
- err_count  out  ERR_W  saturating count of frame errors.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; latch edge register cleared; partial frame discarded. Applies identically mid-frame.
- Byte accept: accept = command_latch & ~latch_q, where latch_q is the registered command_latch. command_data is consumed on the same clk edge. A held-high latch accepts exactly one byte.
- FSM states: IDLE, OPCODE, ARG, CHECK.
  - IDLE: accepted byte == SYNC_BYTE -> OPCODE. Any other byte is ignored silently, with no error.
  - OPCODE: opcode in table[0..NUM_CMD-1] -> store opcode and index; chk = opcode; go to ARG, or to CHECK if ARG_BYTES==0. Unknown opcode -> frame error, go to IDLE.
  - ARG: shift byte into the arg shadow register; chk ^= byte; byte counter runs 0..ARG_BYTES-1; after the last byte go to CHECK.
  - CHECK: byte == chk -> success. Otherwise frame error. Go to IDLE in either case.
- SYNC_BYTE seen inside a frame is treated as data; there is no resync.
- Success, in the cycle after the checksum byte is consumed:
  - cmd_pulse[idx] = 1 and cmd_valid = 1, each for exactly one cycle.
  - cmd_arg is loaded from the shadow register in that same cycle.
  - Mode update in that same cycle: index 2 (USB) sets mode_usb=1, mode_sd=0. Index 3 (SD) sets mode_sd=1, mode_usb=0. Other commands leave the mode unchanged.
  - mode_usb and mode_sd are never both 1.
- Timeout: a cycle counter runs while state != IDLE and is cleared on every accept. When it reaches TIMEOUT_CYC with no accept, the FSM returns to IDLE and raises a frame error. If an accept and the timeout fall in the same cycle, the accept wins.
- Frame error: frame_err pulses for one cycle, in the cycle after detection. err_count increments and saturates at all-ones. The error does not disturb cmd_arg or the mode.
- Latency: checksum byte consumed at edge t -> outputs high during cycle t+1. Back-to-back frames are supported; the next SYNC may be accepted in the cycle after CHECK.

Decomposition:
- Package cmd_frame_pkg holds:
  - state enum;
  - the opcode table: 8'hAA reset, 8'h55 nframe, 8'h5A usb, 8'hA5 sd, with spares 8'hC3, 8'h3C, 8'h96, 8'h69;
  - named indices CMD_RESET=0, CMD_NFRAME=1, CMD_USB=2, CMD_SD=3;
  - a function mapping opcode -> {hit, index}.
- One sub-module, cmd_byte_strobe: latch edge detect plus inter-byte timeout counter, producing accept and timeout.

Test Plan:
- Bytes EB 55 12 34 73 -> cmd_pulse=4'b0010 for one cycle; cmd_valid=1; cmd_arg=16'h1234; frame_err=0; busy falls the cycle after the last byte.
- EB 5A 00 00 5A, then EB A5 01 02 A6 -> first frame: mode_usb=1, mode_sd=0; second frame: mode_usb=0, mode_sd=1, cmd_arg=16'h0102.
- EB AA 00 00 00 (bad checksum, expected AA) -> no cmd_pulse; frame_err pulse; err_count=1. Then a valid EB AA 00 00 AA -> cmd_pulse=4'b0001.
- EB 33 (unknown opcode) -> frame_err in the cycle after 33 is accepted; FSM in IDLE; err_count increments. Latch held high 50 cycles with byte EB -> only one accept.
- TIMEOUT_CYC=16: EB 55, then no strobe -> frame_err exactly 16 cycles after the last accept; next valid frame decodes correctly. Force err_count to its max -> err_count stays saturated.
- rst_n low after EB 55 12 -> all outputs 0 asynchronously. After release, 34 73 gives no pulse (ignored in IDLE); a full valid frame then works.

Source files
------------

// File: rtl/cmd_frame_decoder_pkg.sv
// Shared types, opcode table and lookup helpers for the framed command decoder.
package cmd_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ARG,
        ST_CHECK
    } state_e;

    localparam int MAX_CMD = 8;

    localparam logic [7:0] OPCODE_TBL [MAX_CMD] = '{
        8'hAA, 8'h55, 8'h5A, 8'hA5, 8'hC3, 8'h3C, 8'h96, 8'h69
    };

    localparam int CMD_RESET  = 0;
    localparam int CMD_NFRAME = 1;
    localparam int CMD_USB    = 2;
    localparam int CMD_SD     = 3;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } op_lookup_t;

    // Only the first num_cmd table entries are live opcodes.
    function automatic op_lookup_t opcode_lookup(input logic [7:0] op, input int num_cmd);
        op_lookup_t r;
        r = '0;
        for (int i = 0; i < MAX_CMD; i++) begin
            if (i < num_cmd && op == OPCODE_TBL[i] && !r.hit) begin
                r.hit = 1'b1;
                r.idx = 3'(i);
            end
        end
        return r;
    endfunction

    function automatic int arg_width(input int arg_bytes);
        return (arg_bytes == 0) ? 8 : 8 * arg_bytes;
    endfunction

endpackage

// File: rtl/cmd_frame_decoder_if.sv
// Host byte strobe plus decoded command/status outputs of the frame decoder.
interface cmd_frame_if
    import cmd_frame_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_CMD   = 4,
    parameter int ARG_BYTES = 2,
    parameter int ERR_W     = 16
);
    localparam int ARG_W = arg_width(ARG_BYTES);

    logic                command_latch;
    logic [DATA_W-1:0]   command_data;
    logic [NUM_CMD-1:0]  cmd_pulse;
    logic                cmd_valid;
    logic [ARG_W-1:0]    cmd_arg;
    logic                mode_usb;
    logic                mode_sd;
    logic                frame_err;
    logic [ERR_W-1:0]    err_count;
    logic                busy;

    modport master (
        output command_latch, command_data,
        input  cmd_pulse, cmd_valid, cmd_arg, mode_usb, mode_sd, frame_err, err_count, busy
    );

    modport slave (
        input  command_latch, command_data,
        output cmd_pulse, cmd_valid, cmd_arg, mode_usb, mode_sd, frame_err, err_count, busy
    );
endinterface

// File: rtl/cmd_byte_strobe.sv
// Rising-edge byte accept and inter-byte timeout counter for the frame decoder.
module cmd_byte_strobe #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic latch_i,
    input  logic busy_i,
    output logic accept_o,
    output logic timeout_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic             latch_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign accept_o  = latch_i & ~latch_q;
    // An accept in the expiry cycle wins over the timeout.
    assign timeout_o = busy_i & ~accept_o & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (accept_o || !busy_i || timeout_o) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            latch_q <= latch_i;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/cmd_frame_decoder.sv
// Framed command decoder: SYNC, opcode, argument bytes, XOR checksum -> command pulse and mode.
module cmd_frame_decoder
    import cmd_frame_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                NUM_CMD     = 4,
    parameter int                ARG_BYTES   = 2,
    parameter logic [DATA_W-1:0] SYNC_BYTE   = 8'hEB,
    parameter int                TIMEOUT_CYC = 1024,
    parameter int                ERR_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    cmd_frame_if.slave  cmd_if
);
    localparam int ARG_W = arg_width(ARG_BYTES);

    logic accept, timeout, busy;
    logic [7:0] byte_in;
    op_lookup_t lk;

    state_e              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          chk_q, chk_d;
    logic [2:0]          bcnt_q, bcnt_d;
    logic [ARG_W-1:0]    arg_sh_q, arg_sh_d;
    logic [ARG_W-1:0]    arg_q, arg_d;
    logic [NUM_CMD-1:0]  pulse_q, pulse_d;
    logic                valid_q, valid_d;
    logic                usb_q, usb_d;
    logic                sd_q, sd_d;
    logic                ferr_q, ferr_d;
    logic [ERR_W-1:0]    ecnt_q, ecnt_d;
    logic                ok, err;

    assign byte_in = cmd_if.command_data[7:0];
    assign lk      = opcode_lookup(byte_in, NUM_CMD);
    assign busy    = (state_q != ST_IDLE);

    cmd_byte_strobe #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_strobe (
        .clk      (clk),
        .rst_n    (rst_n),
        .latch_i  (cmd_if.command_latch),
        .busy_i   (busy),
        .accept_o (accept),
        .timeout_o(timeout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        chk_d    = chk_q;
        bcnt_d   = bcnt_q;
        arg_sh_d = arg_sh_q;
        ok       = 1'b0;
        err      = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_if.command_data == SYNC_BYTE) begin
                        state_d  = ST_OPCODE;
                        bcnt_d   = '0;
                        arg_sh_d = '0;
                    end
                end
                ST_OPCODE: begin
                    if (lk.hit) begin
                        idx_d   = lk.idx;
                        chk_d   = byte_in;
                        state_d = (ARG_BYTES == 0) ? ST_CHECK : ST_ARG;
                    end else begin
                        err     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_ARG: begin
                    arg_sh_d = (arg_sh_q << 8) | ARG_W'(byte_in);
                    chk_d    = chk_q ^ byte_in;
                    bcnt_d   = bcnt_q + 3'd1;
                    if (bcnt_q == 3'(ARG_BYTES - 1)) state_d = ST_CHECK;
                end
                default: begin
                    ok      = (byte_in == chk_q);
                    err     = (byte_in != chk_q);
                    state_d = ST_IDLE;
                end
            endcase
        end else if (timeout) begin
            err     = 1'b1;
            state_d = ST_IDLE;
        end

        // Registered outputs: pulses last exactly the cycle after the deciding byte.
        pulse_d = '0;
        valid_d = 1'b0;
        arg_d   = arg_q;
        usb_d   = usb_q;
        sd_d    = sd_q;
        ferr_d  = err;
        ecnt_d  = ecnt_q;
        if (ok) begin
            pulse_d = NUM_CMD'(1) << idx_q;
            valid_d = 1'b1;
            arg_d   = arg_sh_q;
            if (idx_q == 3'(CMD_USB)) begin
                usb_d = 1'b1;
                sd_d  = 1'b0;
            end else if (idx_q == 3'(CMD_SD)) begin
                usb_d = 1'b0;
                sd_d  = 1'b1;
            end
        end
        if (err && !(&ecnt_q)) ecnt_d = ecnt_q + ERR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            chk_q    <= '0;
            bcnt_q   <= '0;
            arg_sh_q <= '0;
            arg_q    <= '0;
            pulse_q  <= '0;
            valid_q  <= 1'b0;
            usb_q    <= 1'b0;
            sd_q     <= 1'b0;
            ferr_q   <= 1'b0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            chk_q    <= chk_d;
            bcnt_q   <= bcnt_d;
            arg_sh_q <= arg_sh_d;
            arg_q    <= arg_d;
            pulse_q  <= pulse_d;
            valid_q  <= valid_d;
            usb_q    <= usb_d;
            sd_q     <= sd_d;
            ferr_q   <= ferr_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign cmd_if.cmd_pulse = pulse_q;
    assign cmd_if.cmd_valid = valid_q;
    assign cmd_if.cmd_arg   = arg_q;
    assign cmd_if.mode_usb  = usb_q;
    assign cmd_if.mode_sd   = sd_q;
    assign cmd_if.frame_err = ferr_q;
    assign cmd_if.err_count = ecnt_q;
    assign cmd_if.busy      = busy;
endmodule
